prio_encoder_rr: RTL and testbench

//  Parametrised N:log2(N) priority encoder with selectable fixed-LSB, fixed-MSB or round-robin priority.

---
 rtl/prio_encoder_rr_if.sv | 28 ++
 rtl/prio_encoder_rr.sv | 83 ++++++++
 tb/tb_prio_encoder_rr.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/prio_encoder_rr_if.sv
// Handshake and result bundle between a request source and the priority encoder.
// The master modport is the source/consumer side; the slave modport is the encoder.
interface prio_encoder_rr_if #(
  parameter int N = 8
) ();
  localparam int W = $clog2(N);

  logic         en;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] din;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  logic         out_multi;
  logic         out_none;

  modport master (
    output en, in_valid, din, out_ready,
    input  in_ready, out_valid, out_idx, out_onehot, out_multi, out_none
  );

  modport slave (
    input  en, in_valid, din, out_ready,
    output in_ready, out_valid, out_idx, out_onehot, out_multi, out_none
  );
endinterface

// File: rtl/prio_encoder_rr.sv
// N:log2(N) priority encoder with fixed-LSB, fixed-MSB or round-robin priority,
// registered behind a valid/ready handshake with multi-hot and all-zero flags.
module prio_encoder_rr #(
  parameter int N    = 8,
  parameter int MODE = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  prio_encoder_rr_if.slave bus
);
  localparam int W = $clog2(N);

  logic [W-1:0] ptr;
  logic [W-1:0] win;
  logic [W-1:0] pos_w;
  logic [W-1:0] ptr_next;
  logic         found;
  logic         multi;
  logic [N-1:0] onehot;
  int           pos;
  logic         capture;

  assign bus.in_ready = bus.en & (~bus.out_valid | bus.out_ready);
  assign capture      = bus.in_valid & bus.in_ready;

  // Winner search; the round-robin scan wraps modulo N, not modulo 2^W.
  always_comb begin
    win   = '0;
    found = 1'b0;
    pos   = 0;
    pos_w = '0;
    if (MODE == 2) begin
      for (int k = 0; k < N; k++) begin
        pos = int'(ptr) + k;
        if (pos >= N) pos = pos - N;
        pos_w = W'(pos);
        if (!found && bus.din[pos_w]) begin
          found = 1'b1;
          win   = pos_w;
        end
      end
    end else if (MODE == 1) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (!found && bus.din[i]) begin
          found = 1'b1;
          win   = W'(i);
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!found && bus.din[i]) begin
          found = 1'b1;
          win   = W'(i);
        end
      end
    end
  end

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  assign multi    = |(bus.din & (bus.din - N'(1)));
  assign onehot   = found ? (N'(1) << win) : '0;
  assign ptr_next = (win == W'(N - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_idx    <= '0;
      bus.out_onehot <= '0;
      bus.out_multi  <= 1'b0;
      bus.out_none   <= 1'b0;
      ptr            <= '0;
    end else if (capture) begin
      bus.out_valid  <= 1'b1;
      bus.out_idx    <= win;
      bus.out_onehot <= onehot;
      bus.out_multi  <= multi;
      bus.out_none   <= ~found;
      if (MODE == 2 && found) ptr <= ptr_next;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench for prio_encoder_rr covering all three priority modes, a
// non-power-of-two width, backpressure, enable gating and asynchronous reset.
module tb_prio_encoder_rr;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  prio_encoder_rr_if #(.N(8)) b0 ();
  prio_encoder_rr_if #(.N(8)) b1 ();
  prio_encoder_rr_if #(.N(8)) b2 ();
  prio_encoder_rr_if #(.N(6)) b3 ();

  prio_encoder_rr #(.N(8), .MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  prio_encoder_rr #(.N(8), .MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  prio_encoder_rr #(.N(8), .MODE(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  prio_encoder_rr #(.N(6), .MODE(2)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input int sel, input logic e, input logic v,
                               input logic [7:0] d, input logic r);
    case (sel)
      0: begin b0.en = e; b0.in_valid = v; b0.din = d; b0.out_ready = r; end
      1: begin b1.en = e; b1.in_valid = v; b1.din = d; b1.out_ready = r; end
      2: begin b2.en = e; b2.in_valid = v; b2.din = d; b2.out_ready = r; end
      default: begin b3.en = e; b3.in_valid = v; b3.din = d[5:0]; b3.out_ready = r; end
    endcase
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 4; s++) applyStimulus(s, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    checkOutput("rst_valid", b0.out_valid, 0);
    checkOutput("rst_idx", b0.out_idx, 0);
    checkOutput("rst_onehot", b0.out_onehot, 0);
    checkOutput("rst_multi", b0.out_multi, 0);
    checkOutput("rst_none", b0.out_none, 0);
    rst_n = 1'b1;
    step();

    $display("[TB] MODE0 lowest bit wins");
    applyStimulus(0, 1'b1, 1'b1, 8'h24, 1'b1);
    checkOutput("m0_in_ready", b0.in_ready, 1);
    step();
    checkOutput("m0_valid", b0.out_valid, 1);
    checkOutput("m0_idx", b0.out_idx, 2);
    checkOutput("m0_onehot", b0.out_onehot, 8'h04);
    checkOutput("m0_multi", b0.out_multi, 1);
    checkOutput("m0_none", b0.out_none, 0);
    applyStimulus(0, 1'b1, 1'b0, 8'h00, 1'b1);
    step();
    checkOutput("m0_drain", b0.out_valid, 0);

    $display("[TB] MODE1 highest bit wins");
    applyStimulus(1, 1'b1, 1'b1, 8'h24, 1'b1);
    step();
    checkOutput("m1_idx", b1.out_idx, 5);
    checkOutput("m1_onehot", b1.out_onehot, 8'h20);
    checkOutput("m1_multi", b1.out_multi, 1);
    applyStimulus(1, 1'b1, 1'b1, 8'h80, 1'b1);
    step();
    checkOutput("m1_idx7", b1.out_idx, 7);
    checkOutput("m1_onehot7", b1.out_onehot, 8'h80);
    checkOutput("m1_multi7", b1.out_multi, 0);
    checkOutput("m1_valid7", b1.out_valid, 1);
    applyStimulus(1, 1'b1, 1'b0, 8'h00, 1'b1);
    step();
    checkOutput("m1_drain", b1.out_valid, 0);

    $display("[TB] MODE2 N8 round robin over all-ones");
    applyStimulus(2, 1'b1, 1'b1, 8'hFF, 1'b1);
    for (int k = 0; k < 9; k++) begin
      step();
      checkOutput($sformatf("rr8_idx%0d", k), b2.out_idx, k % 8);
      checkOutput($sformatf("rr8_onehot%0d", k), b2.out_onehot, 32'h1 << (k % 8));
      checkOutput($sformatf("rr8_valid%0d", k), b2.out_valid, 1);
    end
    applyStimulus(2, 1'b1, 1'b0, 8'h00, 1'b1);
    step();

    $display("[TB] MODE2 N6 wrap");
    applyStimulus(3, 1'b1, 1'b1, 8'h3F, 1'b1);
    for (int k = 0; k < 7; k++) begin
      step();
      checkOutput($sformatf("rr6_idx%0d", k), b3.out_idx, k % 6);
    end
    applyStimulus(3, 1'b1, 1'b0, 8'h00, 1'b1);
    step();
    checkOutput("rr6_drain", b3.out_valid, 0);

    $display("[TB] backpressure");
    applyStimulus(0, 1'b1, 1'b1, 8'h10, 1'b1);
    step();
    applyStimulus(0, 1'b1, 1'b1, 8'h01, 1'b0);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("bp_in_ready%0d", k), b0.in_ready, 0);
      checkOutput($sformatf("bp_valid%0d", k), b0.out_valid, 1);
      checkOutput($sformatf("bp_idx%0d", k), b0.out_idx, 4);
      checkOutput($sformatf("bp_onehot%0d", k), b0.out_onehot, 8'h10);
      step();
    end
    applyStimulus(0, 1'b1, 1'b1, 8'h01, 1'b1);
    checkOutput("bp_release_ready", b0.in_ready, 1);
    step();
    checkOutput("bp_new_valid", b0.out_valid, 1);
    checkOutput("bp_new_idx", b0.out_idx, 0);
    checkOutput("bp_new_onehot", b0.out_onehot, 8'h01);
    applyStimulus(0, 1'b1, 1'b1, 8'h03, 1'b1);
    step();
    checkOutput("b2b_valid", b0.out_valid, 1);
    checkOutput("b2b_multi", b0.out_multi, 1);
    applyStimulus(0, 1'b1, 1'b0, 8'h00, 1'b1);
    step();
    checkOutput("b2b_drain", b0.out_valid, 0);

    $display("[TB] enable gating");
    applyStimulus(0, 1'b0, 1'b1, 8'h08, 1'b1);
    checkOutput("en0_in_ready", b0.in_ready, 0);
    step();
    checkOutput("en0_no_capture", b0.out_valid, 0);
    applyStimulus(0, 1'b1, 1'b1, 8'h08, 1'b0);
    step();
    checkOutput("en_cap_idx", b0.out_idx, 3);
    applyStimulus(0, 1'b0, 1'b1, 8'h40, 1'b0);
    checkOutput("en0_hold_ready", b0.in_ready, 0);
    step();
    checkOutput("en0_hold_valid", b0.out_valid, 1);
    checkOutput("en0_hold_idx", b0.out_idx, 3);
    applyStimulus(0, 1'b0, 1'b1, 8'h40, 1'b1);
    step();
    checkOutput("en0_drain", b0.out_valid, 0);

    $display("[TB] zero input and pointer hold");
    applyStimulus(2, 1'b1, 1'b1, 8'h00, 1'b1);
    step();
    checkOutput("zero_valid", b2.out_valid, 1);
    checkOutput("zero_none", b2.out_none, 1);
    checkOutput("zero_idx", b2.out_idx, 0);
    checkOutput("zero_onehot", b2.out_onehot, 0);
    checkOutput("zero_multi", b2.out_multi, 0);
    applyStimulus(2, 1'b1, 1'b1, 8'hFF, 1'b1);
    step();
    checkOutput("ptr_hold_idx", b2.out_idx, 1);
    checkOutput("ptr_hold_none", b2.out_none, 0);
    applyStimulus(2, 1'b1, 1'b1, 8'h05, 1'b1);
    step();
    checkOutput("rr_skip_idx", b2.out_idx, 2);

    $display("[TB] async reset mid-transfer");
    applyStimulus(2, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("pre_rst_valid", b2.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", b2.out_valid, 0);
    checkOutput("async_rst_idx", b2.out_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2, 1'b1, 1'b1, 8'hFF, 1'b1);
    step();
    checkOutput("post_rst_idx", b2.out_idx, 0);
    step();
    checkOutput("post_rst_idx_next", b2.out_idx, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
